// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: op codes, state encoding and RUN operand field positions
// shared by the counter sequencer and its testbench.
package counter_seq_pkg;

  localparam logic [1:0] OP_LOAD_LIMIT = 2'd0;
  localparam logic [1:0] OP_LOAD_COUNT = 2'd1;
  localparam logic [1:0] OP_RUN        = 2'd2;
  localparam logic [1:0] OP_STOP       = 2'd3;

  // RUN operand layout: bit0 direction (1 = down), bit1 one-shot, [7:4] prescale
  localparam int RUN_DIR_BIT     = 0;
  localparam int RUN_ONESHOT_BIT = 1;
  localparam int RUN_PRE_LSB     = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RUNNING = 1'b1
  } seq_state_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if: command channel plus counter status outputs.
// master = command issuer, slave = the sequencer.
interface counter_sequencer_if #(parameter int WIDTH = 8);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             wrap;
  logic             err;

  modport master (output cmd_valid, cmd_op, cmd_data,
                  input  cmd_ready, count, busy, done, wrap, err);
  modport slave  (input  cmd_valid, cmd_op, cmd_data,
                  output cmd_ready, count, busy, done, wrap, err);
endinterface

// File: rtl/counter_seq_prescaler.sv
// counter_seq_prescaler: step divider. tick is high on an enabled cycle when
// the phase counter matches pre, giving one tick every pre+1 enabled cycles.
// Built only when COUNTER_SEQ_PRESCALE_EN is defined.
`ifdef COUNTER_SEQ_PRESCALE_EN
module counter_seq_prescaler #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clear,
  input  logic [PRE_W-1:0] pre,
  output logic             tick
);

  logic [PRE_W-1:0] r_cnt;

  assign tick = ena && (r_cnt == pre);

  // phase counter: clear wins (RUN start), then wrap on tick, else count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (clear) r_cnt <= '0;
    else if (ena)   r_cnt <= tick ? '0 : r_cnt + 1'b1;
  end

endmodule
`endif

// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven up/down counter with programmable limit,
// continuous or one-shot runs. Optional step prescaler enabled by defining
// COUNTER_SEQ_PRESCALE_EN; without it a step happens every enabled cycle.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  counter_sequencer_if.slave  bus
);

  seq_state_t       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_limit;
  logic             r_dir;
  logic             r_oneshot;
  logic             r_done;
  logic             r_wrap;
  logic             r_err;

  logic w_running;
  logic w_acc;
  logic w_stop;
  logic w_term;
  logic w_step;

  assign w_running = (r_state == ST_RUNNING);
  assign w_acc     = bus.cmd_valid && ena;
  assign w_stop    = w_acc && (bus.cmd_op == OP_STOP);
  assign w_term    = r_dir ? (r_count == '0) : (r_count >= r_limit);

`ifdef COUNTER_SEQ_PRESCALE_EN
  logic [PRE_W-1:0] r_pre;
  logic             w_pre_clr;
  logic             w_pre_ena;

  assign w_pre_clr = w_acc && !w_running && (bus.cmd_op == OP_RUN);
  assign w_pre_ena = ena && w_running;

  counter_seq_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (w_pre_ena),
    .clear (w_pre_clr),
    .pre   (r_pre),
    .tick  (w_step)
  );

  // prescale value is captured from the RUN operand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_pre <= '0;
    else if (w_pre_clr) r_pre <= bus.cmd_data[RUN_PRE_LSB +: PRE_W];
  end
`else
  localparam int unused_pre_w = PRE_W;
  assign w_step = ena && w_running;
`endif

  // sequencer: command decode, stepping and registered event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_limit   <= '1;
      r_dir     <= 1'b0;
      r_oneshot <= 1'b0;
      r_done    <= 1'b0;
      r_wrap    <= 1'b0;
      r_err     <= 1'b0;
    end else if (ena) begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            case (bus.cmd_op)
              OP_LOAD_LIMIT: r_limit <= bus.cmd_data;
              OP_LOAD_COUNT: r_count <= bus.cmd_data;
              OP_RUN: begin
                r_dir     <= bus.cmd_data[RUN_DIR_BIT];
                r_oneshot <= bus.cmd_data[RUN_ONESHOT_BIT];
                r_state   <= ST_RUNNING;
              end
              default: ;
            endcase
          end
        end
        ST_RUNNING: begin
          // a STOP beats a coincident step: no count change, no pulse
          if (w_stop) begin
            r_state <= ST_IDLE;
          end else begin
            if (w_acc) r_err <= 1'b1;
            if (w_step) begin
              if (!w_term) begin
                r_count <= r_dir ? r_count - 1'b1 : r_count + 1'b1;
              end else if (r_oneshot) begin
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end else begin
                r_count <= r_dir ? r_limit : '0;
                r_wrap  <= 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end else begin
      // pulses are not replayed once ena returns
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end
  end

  assign bus.cmd_ready = ena;
  assign bus.count     = r_count;
  assign bus.busy      = w_running;
  assign bus.done      = r_done && ena;
  assign bus.wrap      = r_wrap && ena;
  assign bus.err       = r_err  && ena;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed plus random commands; a behavioural model
// pushes the expected status after every edge and a monitor compares it.
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  typedef struct {
    int cnt;
    bit busy;
    bit done;
    bit wrap;
    bit err;
  } exp_t;

`ifdef COUNTER_SEQ_PRESCALE_EN
  localparam bit PRE_ON = 1'b1;
`else
  localparam bit PRE_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic ena;
  counter_sequencer_if #(.WIDTH(8)) bus();

  counter_sequencer #(.WIDTH(8), .PRE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  exp_t q[$];

  // reference state
  bit m_run, m_dir, m_os, m_done, m_wrap, m_err;
  int m_cnt, m_lim, m_pre, m_n;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_dir = 0; m_os = 0; m_done = 0; m_wrap = 0; m_err = 0;
    m_cnt = 0; m_lim = 255; m_pre = 0; m_n = 0;
  endtask

  // one clock edge of the specified behaviour, using the inputs now applied
  task automatic model_edge();
    logic [7:0] d;
    bit acc, step;
    exp_t e;
    d = bus.cmd_data;
    m_done = 0; m_wrap = 0; m_err = 0;
    if (ena) begin
      acc = bus.cmd_valid;
      if (!m_run) begin
        if (acc) begin
          if (bus.cmd_op == OP_LOAD_LIMIT) m_lim = d;
          else if (bus.cmd_op == OP_LOAD_COUNT) m_cnt = d;
          else if (bus.cmd_op == OP_RUN) begin
            m_dir = d[0];
            m_os  = d[1];
            m_pre = PRE_ON ? int'(d[7:4]) : 0;
            m_n   = 0;
            m_run = 1;
          end
        end
      end else begin
        m_n++;
        step = (m_n % (m_pre + 1)) == 0;
        if (acc && bus.cmd_op == OP_STOP) begin
          m_run = 0;
        end else begin
          if (acc) m_err = 1;
          if (step) begin
            if ((!m_dir && m_cnt >= m_lim) || (m_dir && m_cnt == 0)) begin
              if (m_os) begin
                m_done = 1;
                m_run  = 0;
              end else begin
                m_cnt  = m_dir ? m_lim : 0;
                m_wrap = 1;
              end
            end else begin
              m_cnt = m_dir ? m_cnt - 1 : (m_cnt + 1) % 256;
            end
          end
        end
      end
    end
    e.cnt = m_cnt; e.busy = m_run; e.done = m_done; e.wrap = m_wrap; e.err = m_err;
    q.push_back(e);
  endtask

  task automatic drive(input bit e, input bit v, input logic [1:0] op, input logic [7:0] d);
    ena = e;
    bus.cmd_valid = v;
    bus.cmd_op = op;
    bus.cmd_data = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, OP_STOP, 8'h00);
  endtask

  // monitor: pop one expectation per cycle and compare all status outputs
  initial begin
    exp_t e;
    logic [12:0] act, exp;
    forever begin
      @(negedge clk);
      if (chk_en && q.size() > 0) begin
        e = q.pop_front();
        act = {bus.count, bus.busy, bus.done, bus.wrap, bus.err, bus.cmd_ready};
        exp = {8'(e.cnt), e.busy, e.done & ena, e.wrap & ena, e.err & ena, ena};
        chk("status{cnt,busy,done,wrap,err,rdy}", int'(act), int'(exp));
      end
    end
  end

  initial begin
    logic [1:0] op;
    logic [7:0] d;
    ena = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = OP_STOP;
    bus.cmd_data = 8'h00;
    rst_n = 1'b0;
    model_reset();
    #3;
    chk("reset_count", int'(bus.count), 0);
    chk("reset_busy",  int'(bus.busy), 0);
    chk("reset_pulses", int'({bus.done, bus.wrap, bus.err}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // asynchronous reset mid-run
    drive(1, 1, OP_LOAD_COUNT, 8'h55);
    drive(1, 1, OP_RUN, 8'h00);
    idle(3);
    chk_en = 1'b0;
    q.delete();
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", int'(bus.count), 0);
    chk("async_rst_busy",  int'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;

    // up one-shot from reset values runs to 0xFF
    drive(1, 1, OP_RUN, 8'h02);
    idle(260);
    chk("oneshot_ff_count", int'(bus.count), 8'hFF);
    chk("oneshot_ff_busy",  int'(bus.busy), 0);

    // up one-shot to 5
    drive(1, 1, OP_LOAD_LIMIT, 8'd5);
    drive(1, 1, OP_LOAD_COUNT, 8'd0);
    drive(1, 1, OP_RUN, 8'h02);
    idle(8);
    chk("oneshot5_count", int'(bus.count), 5);

    // down continuous with an illegal LOAD_LIMIT and an ena gap
    drive(1, 1, OP_LOAD_LIMIT, 8'd3);
    drive(1, 1, OP_LOAD_COUNT, 8'd1);
    drive(1, 1, OP_RUN, 8'h01);
    idle(4);
    drive(1, 1, OP_LOAD_LIMIT, 8'd9);
    idle(2);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, OP_STOP, 8'h00);
    idle(5);
    drive(1, 1, OP_STOP, 8'h00);

    // limit 0 up run: terminal on first step
    drive(1, 1, OP_LOAD_LIMIT, 8'd0);
    drive(1, 1, OP_LOAD_COUNT, 8'd7);
    drive(1, 1, OP_RUN, 8'h00);
    idle(3);
    drive(1, 1, OP_STOP, 8'h00);

    // prescaler pre=3 from count 0
    drive(1, 1, OP_LOAD_LIMIT, 8'hFF);
    drive(1, 1, OP_LOAD_COUNT, 8'd0);
    drive(1, 1, OP_RUN, 8'h30);
    idle(4);
    chk("prescale_first_step", int'(bus.count), PRE_ON ? 1 : 4);
    idle(9);
    drive(1, 1, OP_STOP, 8'h00);

    // STOP on the terminal-step cycle of a one-shot
    drive(1, 1, OP_LOAD_LIMIT, 8'd3);
    drive(1, 1, OP_LOAD_COUNT, 8'd0);
    drive(1, 1, OP_RUN, 8'h02);
    idle(3);
    drive(1, 1, OP_STOP, 8'h00);
    idle(2);
    chk("race_count", int'(bus.count), 3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      op = 2'($urandom_range(0, 3));
      if (m_run && op == OP_STOP && $urandom_range(0, 3) != 0) op = OP_LOAD_LIMIT;
      if (op == OP_RUN)
        d = {2'b00, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3))};
      else if ($urandom_range(0, 1) == 1)
        d = 8'($urandom_range(0, 15));
      else
        d = 8'($urandom);
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 3), op, d);
    end

    idle(2);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
